// File: rtl/flash_seq_pkg.sv
// Shared types and width helpers for the flash command sequencer.
package flash_seq_pkg;

    typedef enum logic [1:0] {
        OpRead    = 2'd0,
        OpProg    = 2'd1,
        OpPgErase = 2'd2,
        OpBkErase = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StIssue,
        StRpush,
        StFin
    } state_e;

    function automatic int word_w(input int words_per_page);
        return $clog2(words_per_page);
    endfunction

    function automatic int addr_w(input int pages_per_bank, input int words_per_page);
        return $clog2(pages_per_bank) + $clog2(words_per_page);
    endfunction

endpackage

// File: rtl/flash_cmd_seq.sv
// Splits read/program/erase commands into single-word flash operations and
// streams program data in and read data out over valid/ready.
module flash_cmd_seq
    import flash_seq_pkg::*;
#(
    parameter int PagesPerBank = 256,
    parameter int WordsPerPage = 256,
    parameter int DataWidth    = 32,
    localparam int WordW       = word_w(WordsPerPage),
    localparam int AddrW       = addr_w(PagesPerBank, WordsPerPage)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [AddrW-1:0]     cmd_addr_i,
    input  logic [AddrW-1:0]     cmd_len_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rdata_valid_o,
    input  logic                 rdata_ready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 flash_req_o,
    output logic                 flash_rd_o,
    output logic                 flash_prog_o,
    output logic                 flash_pg_erase_o,
    output logic                 flash_bk_erase_o,
    output logic [AddrW-1:0]     flash_addr_o,
    output logic [DataWidth-1:0] flash_prog_data_o,
    input  logic                 flash_rd_done_i,
    input  logic                 flash_prog_done_i,
    input  logic                 flash_erase_done_i,
    input  logic [DataWidth-1:0] flash_rd_data_i,
    input  logic                 flash_init_busy_i
);

    localparam int            WordsPerBank = PagesPerBank * WordsPerPage;
    localparam logic [AddrW:0] LastWord    = (AddrW+1)'(WordsPerBank - 1);

    state_e                 r_state, w_state_next;
    cmd_op_e                r_op, w_op_next;
    logic [AddrW-1:0]       r_addr, w_addr_next;
    logic [AddrW-1:0]       r_rem, w_rem_next;
    logic                   r_err, w_err_next;
    logic                   r_alive;
    logic [DataWidth-1:0]   r_prog_data, w_prog_data_next;
    logic [DataWidth-1:0]   r_rdata, w_rdata_next;

    logic [AddrW:0]         w_end_addr;
    logic                   w_range_err;
    logic                   w_complete;
    logic                   w_cmd_ready;
    logic                   w_last;
    logic [AddrW-1:0]       w_addr_inc;

    assign w_end_addr  = {1'b0, cmd_addr_i} + {1'b0, cmd_len_i};
    assign w_range_err = (cmd_op_i == OpRead || cmd_op_i == OpProg) && (w_end_addr > LastWord);
    assign w_last      = (r_rem == '0);
    assign w_addr_inc  = r_addr + AddrW'(1);
    // r_alive keeps ready low while in reset so every output reads 0 there.
    assign w_cmd_ready = (r_state == StIdle) && r_alive && !flash_init_busy_i;

    always_comb begin
        unique case (r_op)
            OpRead:  w_complete = flash_rd_done_i;
            OpProg:  w_complete = flash_prog_done_i;
            default: w_complete = flash_erase_done_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_op_next        = r_op;
        w_addr_next      = r_addr;
        w_rem_next       = r_rem;
        w_err_next       = r_err;
        w_prog_data_next = r_prog_data;
        w_rdata_next     = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid_i && w_cmd_ready) begin
                    w_op_next   = cmd_op_e'(cmd_op_i);
                    w_addr_next = cmd_addr_i;
                    w_rem_next  = cmd_len_i;
                    w_err_next  = w_range_err;
                    if (w_range_err)             w_state_next = StFin;
                    else if (cmd_op_i == OpProg) w_state_next = StWdata;
                    else                         w_state_next = StIssue;
                end
            end
            StWdata: begin
                if (wdata_valid_i) begin
                    w_prog_data_next = wdata_i;
                    w_state_next     = StIssue;
                end
            end
            StIssue: begin
                if (w_complete) begin
                    unique case (r_op)
                        OpRead: begin
                            w_rdata_next = flash_rd_data_i;
                            w_state_next = StRpush;
                        end
                        OpProg: begin
                            if (w_last) begin
                                w_state_next = StFin;
                            end else begin
                                w_rem_next   = r_rem - AddrW'(1);
                                w_addr_next  = w_addr_inc;
                                w_state_next = StWdata;
                            end
                        end
                        default: w_state_next = StFin;
                    endcase
                end
            end
            StRpush: begin
                if (rdata_ready_i) begin
                    if (w_last) begin
                        w_state_next = StFin;
                    end else begin
                        w_rem_next   = r_rem - AddrW'(1);
                        w_addr_next  = w_addr_inc;
                        w_state_next = StIssue;
                    end
                end
            end
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op        <= OpRead;
            r_addr      <= '0;
            r_rem       <= '0;
            r_err       <= 1'b0;
            r_alive     <= 1'b0;
            r_prog_data <= '0;
            r_rdata     <= '0;
        end else begin
            r_op        <= w_op_next;
            r_addr      <= w_addr_next;
            r_rem       <= w_rem_next;
            r_err       <= w_err_next;
            r_alive     <= 1'b1;
            r_prog_data <= w_prog_data_next;
            r_rdata     <= w_rdata_next;
        end
    end

    // Flash-side outputs decode registered state only, so done inputs never loop back into req.
    always_comb begin
        flash_addr_o = '0;
        if (r_state == StIssue) begin
            unique case (r_op)
                OpRead, OpProg: flash_addr_o = r_addr;
                OpPgErase:      flash_addr_o = {r_addr[AddrW-1:WordW], {WordW{1'b0}}};
                default:        flash_addr_o = '0;
            endcase
        end
    end

    assign cmd_ready_o       = w_cmd_ready;
    assign wdata_ready_o     = (r_state == StWdata);
    assign rdata_valid_o     = (r_state == StRpush);
    assign rdata_o           = r_rdata;
    assign busy_o            = (r_state != StIdle);
    assign done_o            = (r_state == StFin);
    assign err_o             = (r_state == StFin) && r_err;
    assign flash_req_o       = (r_state == StIssue);
    assign flash_rd_o        = (r_state == StIssue) && (r_op == OpRead);
    assign flash_prog_o      = (r_state == StIssue) && (r_op == OpProg);
    assign flash_pg_erase_o  = (r_state == StIssue) && (r_op == OpPgErase);
    assign flash_bk_erase_o  = (r_state == StIssue) && (r_op == OpBkErase);
    assign flash_prog_data_o = r_prog_data;

endmodule

// File: doc/flash_cmd_seq.md
Name: flash_cmd_seq

Overview:
- Command sequencer directly upstream of the generic flash primitive.
- Accepts one controller command at a time: read N words, program N words, page erase, or bank erase.
- Breaks each command into single-word flash operations and streams program data in and read data out over valid/ready.
- Holds the flash request, opcode, address and data stable until the matching done pulse. Host-path reads are outside this block.

Parameters:
- PagesPerBank, 256, pages per bank.
- WordsPerPage, 256, words per page.
- DataWidth, 32, flash word width.
- Derived localparams: WordW = clog2(WordsPerPage); AddrW = clog2(PagesPerBank) + WordW; WordsPerBank = PagesPerBank * WordsPerPage.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_op_i  in  2  opcode: 0 read, 1 program, 2 page erase, 3 bank erase
- cmd_addr_i  in  AddrW  start word address
- cmd_len_i  in  AddrW  word count minus 1 (read/program only)
- wdata_valid_i  in  1  program word offered
- wdata_ready_o  out  1  program word accepted
- wdata_i  in  DataWidth  program word
- rdata_valid_o  out  1  read word available
- rdata_ready_i  in  1  read word consumed
- rdata_o  out  DataWidth  read word
- busy_o  out  1  command in progress (state != IDLE)
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  one-cycle pulse: command rejected for range
- flash_req_o  out  1  flash request
- flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o  out  1 each  one-hot opcode qualifiers
- flash_addr_o  out  AddrW  flash word address
- flash_prog_data_o  out  DataWidth  program data
- flash_rd_done_i, flash_prog_done_i, flash_erase_done_i  in  1 each  done pulses from the primitive
- flash_rd_data_i  in  DataWidth  read data, valid in the flash_rd_done_i cycle
- flash_init_busy_i  in  1  flash initialising

Behaviour:
- Reset values: all outputs 0, state IDLE, all registers 0. Reset mid-operation aborts immediately; no done_o or err_o pulse.
- States: IDLE, WDATA, ISSUE, RPUSH, FIN.
- IDLE:
  - cmd_ready_o = !flash_init_busy_i.
  - On accept, latch op, address register a = cmd_addr_i, and remaining count r = cmd_len_i.
  - Range check (read/program): cmd_addr_i + cmd_len_i computed at AddrW+1 bits. If the sum exceeds WordsPerBank-1, go to FIN with err set; no flash activity.
  - Otherwise: read -> ISSUE; program -> WDATA; erase -> ISSUE.
- WDATA:
  - wdata_ready_o = 1.
  - On handshake, register the word into flash_prog_data_o and go to ISSUE.
- ISSUE:
  - flash_req_o = 1, with exactly one qualifier set per latched op.
  - flash_addr_o: a for read/program; {a[AddrW-1:WordW], WordW'b0} for page erase; 0 for bank erase.
  - Completion event: read = flash_rd_done_i; program = flash_prog_done_i (ignore flash_rd_done_i seen during the program's internal read); erase = flash_erase_done_i.
  - Read completion: capture flash_rd_data_i into rdata_o and go to RPUSH.
  - Program completion: if r == 0 go to FIN; else decrement r, increment a, go to WDATA.
  - Erase completion: go to FIN.
  - Req, qualifiers, addr and prog data stay stable from entry until the completion cycle. Done pulses outside ISSUE are ignored.
- RPUSH:
  - rdata_valid_o = 1; rdata_o stays stable until rdata_ready_i.
  - On handshake: if r == 0 go to FIN; else decrement r, increment a, go to ISSUE.
- FIN:
  - done_o = 1 for one cycle; err_o = 1 that same cycle if a range error occurred. Return to IDLE.
  - cmd_ready_o = 0 in FIN; the next command can be accepted the following cycle.
- flash_req_o is decoded from registered state only, with no combinational path from done inputs. The primitive is never idle while this block is in ISSUE after completion, so no duplicate operation is issued.
- Back-to-back operations: the cycle after a completion, a new ISSUE may present the next address.
- Address never wraps; the range check guarantees a <= WordsPerBank-1.
- cmd_len_i is ignored for erase commands.
- Latency, read of 1 word with no host contention: accept -> ISSUE next cycle -> flash_rd_done_i 2 cycles later -> rdata_valid_o next cycle.

Decomposition:
- Shared package flash_seq_pkg holds:
  - enum of cmd_op (OpRead, OpProg, OpPgErase, OpBkErase);
  - state enum;
  - AddrW/WordW helper functions.
- No sub-module; a single FSM with address/count datapath.

Test Plan:
- Read len=3 at addr 0x0010, rdata_ready_i always 1 -> four flash reads at 0x10..0x13, four rdata beats with the memory contents in order, then one done_o, err_o=0.
- Program len=1 at 0x0020, wdata 0xA5A5_0000 then 0x0000_FFFF, wdata_valid_i delayed 5 cycles each -> two program ops at 0x20/0x21; flash_req_o low while waiting for data; readback returns 0xA5A5_0000, 0x0000_FFFF (starting from erased memory).
- Page erase with addr 0x0135 -> flash_addr_o = 0x0100, flash_pg_erase_o=1, req held until flash_erase_done_i; bank erase -> flash_addr_o = 0; done_o pulses once per command.
- Read addr 0xFFFE len=2 (default params) -> no flash_req_o ever, done_o and err_o together one cycle after accept.
- Read len=1 with rdata_ready_i low for 10 cycles -> rdata_o stable, second flash read not issued until the first beat is consumed; flash_init_busy_i high -> cmd_ready_o = 0.
- Assert rst_ni mid-program in ISSUE -> all outputs 0 asynchronously; after release, a new read command completes normally.
